// File: rtl/magphase_recombine_pkg.sv
// rtl/magphase_recombine_pkg.sv - widths, rounding constants and join FSM states for magphase_recombine
package magphase_recombine_pkg;

  localparam int SAMPLE_W = 16;
  localparam int GAIN_W   = 16;

  localparam logic [7:0]        SR_OUT_GAIN_DEF = 8'd192;
  localparam logic [GAIN_W-1:0] GAIN_RESET_DEF  = 16'h1000;

  // mag x norm is Q1.15 x Q1.15; gain is unsigned Q4.12
  localparam int RND1_SHIFT = 15;
  localparam int RND2_SHIFT = 12;
  localparam int RND1       = 1 << (RND1_SHIFT - 1);
  localparam int RND2       = 1 << (RND2_SHIFT - 1);

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_DRAIN_MAG,
    ST_DRAIN_NORM
  } state_t;

endpackage

// File: rtl/magphase_scale_lane.sv
// rtl/magphase_scale_lane.sv - one I/Q component: mag*norm, round, *gain, round, saturate
module magphase_scale_lane
  import magphase_recombine_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en,
  input  logic [SAMPLE_W-1:0] i_mag,
  input  logic [SAMPLE_W-1:0] i_norm,
  input  logic [GAIN_W-1:0]   i_gain,
  output logic [SAMPLE_W-1:0] o_sample
);

  localparam int P_W  = 2 * SAMPLE_W;
  localparam int R2_W = P_W + 2 - RND2_SHIFT;
  localparam logic signed [R2_W-1:0] SAT_MAX = R2_W'(2 ** (SAMPLE_W - 1) - 1);
  localparam logic signed [R2_W-1:0] SAT_MIN = R2_W'(-(2 ** (SAMPLE_W - 1)));

  logic [P_W-1:0]             r_s1;
  logic [SAMPLE_W-1:0]        r_sat;
  logic [P_W:0]               w_sum1;
  logic signed [SAMPLE_W:0]   w_r1;
  logic signed [P_W+1:0]      w_s2;
  logic [P_W+1:0]             w_sum2;
  logic signed [R2_W-1:0]     w_r2;
  logic [SAMPLE_W-1:0]        w_sat;
  logic                       w_unused;

  assign w_sum1 = {r_s1[P_W-1], r_s1} + (P_W + 1)'(RND1);
  assign w_r1   = w_sum1[P_W-1:RND1_SHIFT];
  assign w_s2   = w_r1 * $signed({1'b0, i_gain});
  assign w_sum2 = w_s2 + (P_W + 2)'(RND2);
  assign w_r2   = w_sum2[P_W+1:RND2_SHIFT];

  always_comb begin
    w_sat = w_r2[SAMPLE_W-1:0];
    if (w_r2 > SAT_MAX) begin
      w_sat = {1'b0, {(SAMPLE_W-1){1'b1}}};
    end else if (w_r2 < SAT_MIN) begin
      w_sat = {1'b1, {(SAMPLE_W-1){1'b0}}};
    end
  end

  // r_s1 is stage 1; r_sat is stage 2 and samples the gain as the pair moves in
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1  <= '0;
      r_sat <= '0;
    end else if (i_en) begin
      r_s1  <= $signed(i_mag) * $signed(i_norm);
      r_sat <= w_sat;
    end
  end

  assign o_sample = r_sat;
  assign w_unused = &{1'b0, w_sum1[P_W], w_sum1[RND1_SHIFT-1:0], w_sum2[RND2_SHIFT-1:0]};

endmodule

// File: rtl/magphase_recombine.sv
// rtl/magphase_recombine.sv - joins mag and normalized SC16 streams into gained SC16; MAGPHASE_RECOMBINE_ERRCNT_EN enables err_count
module magphase_recombine
  import magphase_recombine_pkg::*;
#(
  parameter logic [7:0]        SR_OUT_GAIN = SR_OUT_GAIN_DEF,
  parameter logic [GAIN_W-1:0] GAIN_RESET  = GAIN_RESET_DEF
) (
  input  logic        ce_clk,
  input  logic        ce_rst,
  input  logic        clear,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [31:0] mag_tdata,
  input  logic        mag_tlast,
  input  logic        mag_tvalid,
  output logic        mag_tready,
  input  logic [31:0] norm_tdata,
  input  logic        norm_tlast,
  input  logic        norm_tvalid,
  output logic        norm_tready,
  output logic [31:0] o_tdata,
  output logic        o_tlast,
  output logic        o_tvalid,
  input  logic        o_tready,
  output logic [15:0] err_count
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [GAIN_W-1:0]   r_gain;
  logic                r_v1, r_v2, r_v3;
  logic                r_l1, r_l2, r_l3;
  logic [31:0]         r_tdata;
  logic                w_adv;
  logic                w_fire;
  logic                w_mismatch;
  logic                w_mag_rdy;
  logic                w_norm_rdy;
  logic [SAMPLE_W-1:0] w_i;
  logic [SAMPLE_W-1:0] w_q;
  logic                w_unused;

  assign w_adv      = ~r_v3 | o_tready;
  assign w_mismatch = w_fire & (mag_tlast ^ norm_tlast);

  // Readiness includes both valids so a beat is only ever taken as part of a pair
  always_comb begin
    w_state_nxt = r_state;
    w_fire      = 1'b0;
    w_mag_rdy   = 1'b0;
    w_norm_rdy  = 1'b0;
    case (r_state)
      ST_SYNC: begin
        w_fire     = mag_tvalid & norm_tvalid & w_adv & ~clear;
        w_mag_rdy  = w_fire;
        w_norm_rdy = w_fire;
        if (w_mismatch) begin
          w_state_nxt = mag_tlast ? ST_DRAIN_NORM : ST_DRAIN_MAG;
        end
      end
      ST_DRAIN_NORM: begin
        w_norm_rdy = ~clear;
        if (norm_tvalid && norm_tlast && !clear) begin
          w_state_nxt = ST_SYNC;
        end
      end
      ST_DRAIN_MAG: begin
        w_mag_rdy = ~clear;
        if (mag_tvalid && mag_tlast && !clear) begin
          w_state_nxt = ST_SYNC;
        end
      end
      default: w_state_nxt = ST_SYNC;
    endcase
  end

  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      r_state <= ST_SYNC;
    end else if (clear) begin
      r_state <= ST_SYNC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign mag_tready  = w_mag_rdy & ~ce_rst;
  assign norm_tready = w_norm_rdy & ~ce_rst;

  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      r_gain <= GAIN_RESET;
    end else if (set_stb && set_addr == SR_OUT_GAIN) begin
      r_gain <= set_data[GAIN_W-1:0];
    end
  end

  magphase_scale_lane u_lane_i (
    .i_clk    (ce_clk),
    .i_rst    (ce_rst),
    .i_en     (w_adv),
    .i_mag    (mag_tdata[31:16]),
    .i_norm   (norm_tdata[31:16]),
    .i_gain   (r_gain),
    .o_sample (w_i)
  );

  magphase_scale_lane u_lane_q (
    .i_clk    (ce_clk),
    .i_rst    (ce_rst),
    .i_en     (w_adv),
    .i_mag    (mag_tdata[31:16]),
    .i_norm   (norm_tdata[15:0]),
    .i_gain   (r_gain),
    .o_sample (w_q)
  );

  // The three stages move in lock-step; a stalled output freezes everything behind it
  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      {r_v1, r_v2, r_v3} <= '0;
      {r_l1, r_l2, r_l3} <= '0;
      r_tdata            <= '0;
    end else if (clear) begin
      {r_v1, r_v2, r_v3} <= '0;
      {r_l1, r_l2, r_l3} <= '0;
    end else if (w_adv) begin
      r_v1    <= w_fire;
      r_l1    <= mag_tlast | norm_tlast;
      r_v2    <= r_v1;
      r_l2    <= r_l1;
      r_v3    <= r_v2;
      r_l3    <= r_l2;
      r_tdata <= {w_i, w_q};
    end
  end

  assign o_tdata  = r_tdata;
  assign o_tlast  = r_l3;
  assign o_tvalid = r_v3;

`ifdef MAGPHASE_RECOMBINE_ERRCNT_EN
  logic [15:0] r_err_count;

  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      r_err_count <= '0;
    end else if (clear) begin
      r_err_count <= '0;
    end else if (w_mismatch && r_err_count != 16'hFFFF) begin
      r_err_count <= r_err_count + 16'd1;
    end
  end

  assign err_count = r_err_count;
`else
  assign err_count = '0;
`endif

  assign w_unused = &{1'b0, set_data[31:GAIN_W], mag_tdata[15:0]};

endmodule

// File: doc/magphase_recombine.md
# magphase_recombine

Polar-to-cartesian recombiner: joins a magnitude stream and a unit-magnitude (normalized) SC16 stream and outputs SC16 I/Q = magnitude × normalized × output gain, with saturation. Sits in the compute-engine clock domain between two axi_wrapper sink ports and one axi_wrapper source port, undoing a mag/phase split so that processed magnitude and phase streams can be recombined. Packet boundaries of the two inputs are cross-checked and resynchronized on mismatch.

## Interface
- SR_OUT_GAIN, 192: settings-bus address of the output gain register.
- GAIN_RESET, 16'h1000: reset value of the gain register (Q4.12 unsigned, 1.0).
- ce_clk  in  1  compute-engine clock; all logic on rising edge.
- ce_rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush: pipeline valids, FSM, error count to reset values; gain kept.
- set_stb / set_addr / set_data  in  1/8/32  settings bus; gain = set_data[15:0] when set_stb and set_addr==SR_OUT_GAIN.
- mag_tdata  in  32  magnitude in [31:16] (signed Q1.15, non-negative); [15:0] ignored.
- mag_tlast / mag_tvalid  in  1/1;  mag_tready  out  1.
- norm_tdata  in  32  normalized SC16, I in [31:16], Q in [15:0], signed Q1.15.
- norm_tlast / norm_tvalid  in  1/1;  norm_tready  out  1.
- o_tdata  out  32  SC16 result, I [31:16], Q [15:0].
- o_tlast / o_tvalid  out  1/1;  o_tready  in  1.
- err_count  out  16  saturating count of tlast mismatches.

## Operation
- Join: a pair is accepted only when mag_tvalid & norm_tvalid & adv, where adv = ~stage3_valid | o_tready (whole pipeline advances together). Both treadys driven identically in SYNC.
- Per lane (I and Q, identical): s1 = mag × norm_x (32-bit signed); r1 = (s1 + 2^14) >>> 15 (17-bit signed). s2 = r1 × {1'b0,gain} (34-bit signed); r2 = (s2 + 2^11) >>> 12; saturate r2 to [-32768, 32767].
- Output tlast = mag_tlast | norm_tlast of the accepted pair.
- FSM states: SYNC, DRAIN_MAG, DRAIN_NORM.
  - SYNC, accepted pair, tlasts equal: stay.
  - SYNC, mag_tlast=1, norm_tlast=0: pair processed with o_tlast=1, err_count++, go DRAIN_NORM.
  - SYNC, norm_tlast=1, mag_tlast=0: symmetric, go DRAIN_MAG.
  - DRAIN_NORM: norm_tready=1, mag_tready=0; norm beats discarded (nothing enters pipeline); on accepted beat with norm_tlast go SYNC. DRAIN_MAG symmetric.
- err_count saturates at 16'hFFFF.
- Gain change takes effect on the next pair entering stage 2; in-flight samples at stage 2 or later keep their gain.

## Timing
- Three registered stages (s1, r2/saturate, output register); pair accepted in cycle N appears on o_tvalid at N+3 if o_tready held high.
- Full throughput: one pair per cycle with o_tready=1.
- Backpressure: o_tready=0 with stage3 valid freezes all stages and deasserts both input treadys next-cycle-combinationally (tready combinational from adv and FSM).
- o_tvalid may not drop without a handshake; o_tdata/o_tlast stable while o_tvalid & ~o_tready.
- Reset values: o_tvalid=0, o_tdata=0, o_tlast=0, mag_tready=0, norm_tready=0 while in reset, err_count=0, gain=GAIN_RESET, FSM=SYNC.
- Reset or clear mid-packet: in-flight samples discarded, no partial output beat; next accepted pair starts a fresh packet.
- clear and set_stb in the same cycle: both take effect.

## Configuration
- MAGPHASE_RECOMBINE_ERRCNT_EN: defined → mismatch counter implemented as above. Undefined → counter logic removed, err_count tied to 0; FSM and resync behaviour unchanged.

## Structure
- Package magphase_recombine_pkg: SR_OUT_GAIN default, GAIN_RESET default, sample/gain widths, round constants, FSM state enum.
- One sub-module, magphase_scale_lane: one component's multiply/round/multiply/round/saturate datapath with enable; instantiated twice (I, Q). Join, FSM, gain register, counter, output register live in the top.

## Test plan
- mag=0x4000, norm=0x7FFF_0000, gain=0x1000 → o_tdata=0x4000_0000, out 3 cycles after accept.
- mag=0x7FFF, norm=0x7FFF_8000, gain=0x4000 → o_tdata=0x7FFF_8000 (both lanes saturated).
- 8-beat packets, mag tlast on beat 4, norm tlast on beat 8 → 4 output beats with tlast on 4th, norm beats 5–8 dropped, err_count=1, next packet aligned.
- Random o_tready (50%) over 1000 pairs → output matches golden model in order, no loss/duplication, tdata stable during stalls.
- ce_rst asserted mid-packet with 3 beats in flight → o_tvalid=0 immediately, no residual beats after release, gain=0x1000.
- Gain write 0x2000 during streaming → outputs switch from 1× to 2× exactly at pairs entering stage 2 after the write.
